// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding controller.
// Holds the select encoding for the EX-stage operand muxes, the
// per-stage destination tag, and the producer-match predicate used by
// every comparator in the block.
package fwd_pkg;

    // Width of the destination field carried in every stage tag.
    localparam int TAG_RAW = 5;

    // Architectural register that always reads as zero and is never forwarded.
    localparam int unsigned ZERO_REG = 0;

    // Operand-mux select, {S1,S0}.
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // register file
        FWD_EXMEM = 2'b01,  // EX/MEM result (producer one ahead)
        FWD_MEMWB = 2'b10,  // MEM/WB result (producer two ahead)
        FWD_WB    = 2'b11   // write-back holding register (three ahead)
    } fwd_sel_e;

    // Destination tag of the instruction currently occupying a stage.
    typedef struct packed {
        logic               valid;
        logic               we;
        logic               load;
        logic [TAG_RAW-1:0] rd;
    } stage_tag_t;

    // Empty stage; also what a stall or flush inserts into EX.
    localparam stage_tag_t TAG_BUBBLE = '0;

    // A stage supplies src when it really writes that register and the
    // register is not the hard-wired zero.
    function automatic logic tag_hit(input stage_tag_t tag,
                                     input logic [TAG_RAW-1:0] src);
        return tag.valid && tag.we && (tag.rd == src) &&
               (src != TAG_RAW'(ZERO_REG));
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority comparator for one ID-stage source operand.
// Compares the source address against the EX, MEM and WB tags and
// returns the select of the youngest matching producer, or the register
// file when nothing matches.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [TAG_RAW-1:0] src,
    input  stage_tag_t         ex_tag,
    input  stage_tag_t         mem_tag,
    input  stage_tag_t         wb_tag,
    output fwd_sel_e           sel
);

    // The load flag matters only for hazard detection, not for forwarding.
    logic unused_load;
    assign unused_load = ex_tag.load ^ mem_tag.load ^ wb_tag.load;

    // Youngest producer wins: EX over MEM over WB.
    always_comb begin
        if (tag_hit(ex_tag, src)) begin
            sel = FWD_EXMEM;
        end else if (tag_hit(mem_tag, src)) begin
            sel = FWD_MEMWB;
        end else if (tag_hit(wb_tag, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_unit.sv
// Operand-forwarding controller for the integer pipeline.
// Tracks the destination tags of the instructions in EX, MEM and WB,
// produces the registered operand-mux selects for the instruction
// entering EX, and raises a one-cycle stall on a load-use hazard.
// Optional build macro FWD_STALL_CNT_EN adds a saturating 32-bit count
// of stall cycles on output stall_cnt.
module fwd_unit
    import fwd_pkg::*;
#(
    parameter int RAW  = TAG_RAW,
    parameter int NREG = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_we,
    input  logic           id_load,
    input  logic           flush,
    output logic           stall,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]    stall_cnt,
`endif
    output logic           fwd_a_s0,
    output logic           fwd_a_s1,
    output logic           fwd_b_s0,
    output logic           fwd_b_s1
);

    // Stage tags carry a fixed-width destination field, and every
    // architectural register must be addressable.
    if (RAW != TAG_RAW) begin : g_raw_check
        $error("fwd_unit: RAW must equal fwd_pkg::TAG_RAW");
    end
    if (NREG > (1 << RAW)) begin : g_nreg_check
        $error("fwd_unit: NREG exceeds the RAW address space");
    end

    stage_tag_t ex_q,  ex_d;
    stage_tag_t mem_q, mem_d;
    stage_tag_t wb_q,  wb_d;
    fwd_sel_e   fwd_a_q, fwd_a_d;
    fwd_sel_e   fwd_b_q, fwd_b_d;
    fwd_sel_e   sel_a,   sel_b;
    logic       advance;

    // Operand-A and operand-B comparators, evaluated independently so a
    // register used as both sources yields identical selects.
    fwd_match u_match_a (
        .src     (id_rs),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_a)
    );

    fwd_match u_match_b (
        .src     (id_rt),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_b)
    );

    // Load-use hazard: a load in EX feeds a source of the ID instruction.
    // A flush squashes the consumer, so it also cancels the stall.
    always_comb begin
        stall = id_valid && ex_q.valid && ex_q.load && ex_q.we &&
                (ex_q.rd != RAW'(ZERO_REG)) &&
                ((ex_q.rd == id_rs) || (ex_q.rd == id_rt)) &&
                !flush;
    end

    // Next-state for tags and selects: older stages always shift; EX takes
    // the ID instruction only when it really advances, otherwise a bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        ex_d    = TAG_BUBBLE;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        mem_d   = ex_q;
        wb_d    = mem_q;
        advance = id_valid && !stall && !flush;
        if (advance) begin
            ex_d.valid = 1'b1;
            ex_d.we    = id_we;
            ex_d.load  = id_load;
            ex_d.rd    = id_rd;
            fwd_a_d    = sel_a;
            fwd_b_d    = sel_b;
        end
    end

    // Pipeline tag and select registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it needs no
        // separate sensitivity entry; it is just the highest-priority branch.
        if (!rst_n) begin
            ex_q    <= TAG_BUBBLE;
            mem_q   <= TAG_BUBBLE;
            wb_q    <= TAG_BUBBLE;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            // NOTE: non-blocking assignments let every stage read the
            // pre-edge value of its neighbour, which is what makes the
            // shift EX->MEM->WB happen in one step.
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_s0 = fwd_a_q[0];
    assign fwd_a_s1 = fwd_a_q[1];
    assign fwd_b_s0 = fwd_b_q[0];
    assign fwd_b_s1 = fwd_b_q[1];

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall-cycle counter, holding at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_unit.sv
// Directed bench for fwd_unit: reset, forwarding distance and priority,
// load-use stall, register zero, flush, and reset during a stall.
// Build with FWD_STALL_CNT_EN defined to also check stall_cnt.
module tb_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_we, id_load, flush;
    logic       stall;
    logic       fwd_a_s0, fwd_a_s1, fwd_b_s0, fwd_b_s1;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fwd_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .id_valid (id_valid),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_we    (id_we),
        .id_load  (id_load),
        .flush    (flush),
        .stall    (stall),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .fwd_a_s0 (fwd_a_s0),
        .fwd_a_s1 (fwd_a_s1),
        .fwd_b_s0 (fwd_b_s0),
        .fwd_b_s1 (fwd_b_s1)
    );

    always #5 clk = ~clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic we, input logic ld, input logic fl);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_we    = we;
        id_load  = ld;
        flush    = fl;
    endtask

    task automatic randomize_inputs();
        drive(1'($urandom), 5'($urandom_range(31)), 5'($urandom_range(31)),
              5'($urandom_range(31)), 1'($urandom), 1'($urandom),
              1'($urandom));
    endtask

    function automatic logic [1:0] sel_a();
        return {fwd_a_s1, fwd_a_s0};
    endfunction

    function automatic logic [1:0] sel_b();
        return {fwd_b_s1, fwd_b_s0};
    endfunction

    initial begin
        // Reset held for two cycles with random inputs.
        rst_n = 1'b0;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        check("rst_fwd_a", 32'(sel_a()), 32'd0);
        check("rst_fwd_b", 32'(sel_b()), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("rst_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Back-to-back ALU dependency: ADD r3, then SUB rs=3 rt=4.
        drive(1, 1, 2, 3, 1, 0, 0);
        tick();
        drive(1, 3, 4, 10, 1, 0, 0);
        #1;
        check("alu_stall", 32'(stall), 32'd0);
        tick();
        check("alu_a", 32'(sel_a()), 32'd1);
        check("alu_b", 32'(sel_b()), 32'd0);

        // Distance 2: producer r5, one independent, consumer rs=5.
        drive(1, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 6, 0, 0, 0, 0); tick();
        check("dist2_a", 32'(sel_a()), 32'd2);
        check("dist2_b", 32'(sel_b()), 32'd0);

        // Distance 3.
        drive(1, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0, 0); tick();
        check("dist3_a", 32'(sel_a()), 32'd3);

        // Distance 4: producer has retired, register file supplies it.
        drive(1, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0, 0, 0); tick();
        check("dist4_a", 32'(sel_a()), 32'd0);

        // Priority: r7 written in both EX and MEM; rs=rt=7.
        drive(1, 0, 0, 7, 1, 0, 0); tick();
        drive(1, 0, 0, 7, 1, 0, 0); tick();
        drive(1, 7, 7, 0, 0, 0, 0); tick();
        check("prio_b", 32'(sel_b()), 32'd1);
        check("prio_a_same", 32'(sel_a()), 32'd1);

        // Load-use: LW r9, then consumer rs=9 rt=1.
        drive(1, 0, 0, 9, 1, 1, 0); tick();
        drive(1, 9, 1, 11, 1, 0, 0);
        #1;
        check("lu_stall_on", 32'(stall), 32'd1);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt0", stall_cnt, 32'd0);
`endif
        tick();
        check("lu_bubble_a", 32'(sel_a()), 32'd0);
        check("lu_bubble_b", 32'(sel_b()), 32'd0);
        check("lu_stall_off", 32'(stall), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt1", stall_cnt, 32'd1);
`endif
        tick();
        check("lu_replay_a", 32'(sel_a()), 32'd2);
        check("lu_replay_b", 32'(sel_b()), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt_hold", stall_cnt, 32'd1);
`endif

        // Register zero: load writing r0, consumer reads r0.
        drive(1, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 15, 0, 0, 0);
        #1;
        check("r0_stall", 32'(stall), 32'd0);
        tick();
        check("r0_a", 32'(sel_a()), 32'd0);
        check("r0_b", 32'(sel_b()), 32'd0);

        // Load-use pattern with flush: no stall, consumer squashed.
        drive(1, 0, 0, 12, 1, 1, 0); tick();
        drive(1, 12, 12, 13, 1, 0, 1);
        #1;
        check("fl_stall", 32'(stall), 32'd0);
        tick();
        check("fl_a", 32'(sel_a()), 32'd0);
        check("fl_b", 32'(sel_b()), 32'd0);
        // Squashed r13 writer must not be in EX; the load is now in MEM.
        drive(1, 13, 12, 0, 0, 0, 0);
        #1;
        check("fl_next_stall", 32'(stall), 32'd0);
        tick();
        check("fl_next_a", 32'(sel_a()), 32'd0);
        check("fl_next_b", 32'(sel_b()), 32'd2);

        // Reset during a load-use stall.
        drive(1, 0, 0, 14, 1, 1, 0); tick();
        drive(1, 14, 0, 0, 0, 0, 0);
        #1;
        check("rs_stall_on", 32'(stall), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rs_stall_off", 32'(stall), 32'd0);
        check("rs_fwd_a", 32'(sel_a()), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("rs_cnt", stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
